parking_occupancy_ctrl: RTL and testbench

Occupancy controller for a 4-slot car park.
- Registers sensor events and tracks the occupancy of each slot.
- Derives the free-slot count and a full flag.
- Drives a blinking door-open indicator after every accepted entry or exit.
- Sits between the board sensor/switch inputs and the LED/seven-segment output logic.

---
 rtl/parking_occupancy_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_parking_occupancy_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/parking_occupancy_ctrl.sv
// Occupancy controller for a 4-slot car park.
// Registers entry/exit sensor events against the slot picked by `switch`,
// tracks per-slot occupancy, derives free count / full, and drives a blinking
// door indicator after every accepted event.
// Optional build macro: PARK_FULL_LIGHT_EN adds a blinking full-reject LED.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   entry_sensor        car at entry gate (async level)
//   exit_sensor         car at exit gate (async level)
//   switch[1:0]         target slot for the next event
//   parking_slots[3:0]  occupancy, 1 = occupied
//   capacity[2:0]       free slots 0..4
//   full                all slots occupied
//   door_open_pulse     one-cycle strobe per accepted event
//   door_open_light     door indicator LED
//   full_light          full-reject indicator LED (0 unless macro defined)

// Blink sequencer: 2*DOOR_BLINKS half-periods of BLINK_DIV cycles, starting lit.
module parking_blink_seq #(
    parameter int unsigned BLINK_DIV   = 10000000,
    parameter int unsigned DOOR_BLINKS = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trigger,
    output logic light
);
    localparam int unsigned CNT_W  = $clog2(BLINK_DIV);
    localparam int unsigned HALF_W = $clog2(2 * DOOR_BLINKS);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(BLINK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_MAX = HALF_W'(2 * DOOR_BLINKS - 1);

    typedef enum logic {IDLE, BLINK} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [HALF_W-1:0]  half_q, half_d;
    logic               light_q, light_d;
    logic               last_c;

    assign last_c = (cnt_q == CNT_MAX) && (half_q == HALF_MAX);
    assign light  = light_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            half_q  <= '0;
            light_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            light_q <= light_d;
        end
    end

    // Next state: a trigger always (re)starts the sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trigger) state_d = BLINK;
            BLINK:   if (!trigger && last_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters and light
    always_comb begin
        cnt_d   = cnt_q;
        half_d  = half_q;
        light_d = light_q;
        if (trigger) begin
            cnt_d   = '0;
            half_d  = '0;
            light_d = 1'b1;
        end else if (state_q == BLINK) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                if (half_q == HALF_MAX) begin
                    half_d  = '0;
                    light_d = 1'b0;
                end else begin
                    half_d  = half_q + HALF_W'(1);
                    light_d = ~light_q;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            light_d = 1'b0;
        end
    end
endmodule

module parking_occupancy_ctrl #(
    parameter int unsigned BLINK_DIV   = 10000000,
    parameter int unsigned DOOR_BLINKS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       entry_sensor,
    input  logic       exit_sensor,
    input  logic [1:0] switch,
    output logic [3:0] parking_slots,
    output logic [2:0] capacity,
    output logic       full,
    output logic       door_open_pulse,
    output logic       door_open_light,
    output logic       full_light
);
    logic       ent_s1_q, ent_s2_q, ent_prev_q;
    logic       ext_s1_q, ext_s2_q, ext_prev_q;
    logic [3:0] slots_q, slots_d;
    logic       pulse_q, pulse_d;
    logic       entry_evt_c, exit_evt_c;

    // Synchronizers and edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_s1_q   <= 1'b0;
            ent_s2_q   <= 1'b0;
            ent_prev_q <= 1'b0;
            ext_s1_q   <= 1'b0;
            ext_s2_q   <= 1'b0;
            ext_prev_q <= 1'b0;
        end else begin
            ent_s1_q   <= entry_sensor;
            ent_s2_q   <= ent_s1_q;
            ent_prev_q <= ent_s2_q;
            ext_s1_q   <= exit_sensor;
            ext_s2_q   <= ext_s1_q;
            ext_prev_q <= ext_s2_q;
        end
    end

    assign entry_evt_c = ent_s2_q & ~ent_prev_q;
    assign exit_evt_c  = ext_s2_q & ~ext_prev_q;

    // Event resolution; simultaneous entry and exit cancel each other
    always_comb begin
        slots_d = slots_q;
        pulse_d = 1'b0;
        if (entry_evt_c && !exit_evt_c) begin
            if (!slots_q[switch] && !full) begin
                slots_d[switch] = 1'b1;
                pulse_d         = 1'b1;
            end
        end else if (exit_evt_c && !entry_evt_c) begin
            if (slots_q[switch]) begin
                slots_d[switch] = 1'b0;
                pulse_d         = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            slots_q <= slots_d;
            pulse_q <= pulse_d;
        end
    end

    assign parking_slots   = slots_q;
    assign door_open_pulse = pulse_q;
    assign full            = (slots_q == 4'hF);
    assign capacity        = 3'd4 - (3'(slots_q[0]) + 3'(slots_q[1])
                                   + 3'(slots_q[2]) + 3'(slots_q[3]));

    parking_blink_seq #(
        .BLINK_DIV   (BLINK_DIV),
        .DOOR_BLINKS (DOOR_BLINKS)
    ) u_door_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .trigger (pulse_q),
        .light   (door_open_light)
    );

`ifdef PARK_FULL_LIGHT_EN
    logic full_reject_q, full_reject_d;

    // Entry edge alone while full is a reject worth signalling
    always_comb begin
        full_reject_d = entry_evt_c & ~exit_evt_c & full;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) full_reject_q <= 1'b0;
        else        full_reject_q <= full_reject_d;
    end

    parking_blink_seq #(
        .BLINK_DIV   (BLINK_DIV),
        .DOOR_BLINKS (DOOR_BLINKS)
    ) u_full_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .trigger (full_reject_q),
        .light   (full_light)
    );
`else
    assign full_light = 1'b0;
`endif
endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
module tb_parking_occupancy_ctrl;
    localparam int unsigned BD = 4;
    localparam int unsigned DB = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       entry_sensor;
    logic       exit_sensor;
    logic [1:0] switch;
    logic [3:0] parking_slots;
    logic [2:0] capacity;
    logic       full;
    logic       door_open_pulse;
    logic       door_open_light;
    logic       full_light;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         pulse_cnt = 0;
    logic [3:0] exp_q[$];
    logic [3:0] sb_exp;
    logic [3:0] model = 4'h0;

    always #5 clk = ~clk;

    parking_occupancy_ctrl #(.BLINK_DIV(BD), .DOOR_BLINKS(DB)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .entry_sensor    (entry_sensor),
        .exit_sensor     (exit_sensor),
        .switch          (switch),
        .parking_slots   (parking_slots),
        .capacity        (capacity),
        .full            (full),
        .door_open_pulse (door_open_pulse),
        .door_open_light (door_open_light),
        .full_light      (full_light)
    );

    // Scoreboard: every pulse must match a queued accepted event
    always @(negedge clk) begin
        if (rst_n === 1'b1 && door_open_pulse === 1'b1) begin
            pulse_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse: pulse seen, slots=%b, nothing queued", parking_slots);
            end else begin
                sb_exp = exp_q.pop_front();
                if (parking_slots !== sb_exp) begin
                    n_bad++;
                    $display("FAIL sb_slots: got %b expected %b", parking_slots, sb_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        n_cmp++; if (parking_slots !== 4'b0000) begin n_bad++; $display("FAIL rst_slots: got %b expected 0000", parking_slots); end
        n_cmp++; if (capacity !== 3'd4) begin n_bad++; $display("FAIL rst_capacity: got %0d expected 4", capacity); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL rst_full: got %b expected 0", full); end
        n_cmp++; if (door_open_pulse !== 1'b0) begin n_bad++; $display("FAIL rst_pulse: got %b expected 0", door_open_pulse); end
        n_cmp++; if (door_open_light !== 1'b0) begin n_bad++; $display("FAIL rst_door_light: got %b expected 0", door_open_light); end
        n_cmp++; if (full_light !== 1'b0) begin n_bad++; $display("FAIL rst_full_light: got %b expected 0", full_light); end
    endtask

    // Generic event: model decides acceptance, scoreboard checks slots on pulse
    task automatic run_event(input bit ent, input bit ext, input logic [1:0] sw, input string name);
        int         p0;
        bit         acc;
        logic [3:0] nxt;
        nxt = model;
        acc = 1'b0;
        if (ent && !ext && !model[sw] && model != 4'hF) begin
            nxt[sw] = 1'b1; acc = 1'b1;
        end else if (ext && !ent && model[sw]) begin
            nxt[sw] = 1'b0; acc = 1'b1;
        end
        @(negedge clk);
        switch = sw;
        p0 = pulse_cnt;
        if (acc) exp_q.push_back(nxt);
        entry_sensor = ent;
        exit_sensor  = ext;
        repeat (10) @(negedge clk);
        entry_sensor = 1'b0;
        exit_sensor  = 1'b0;
        repeat (4) @(negedge clk);
        model = nxt;
        n_cmp++; if (pulse_cnt - p0 != (acc ? 1 : 0)) begin n_bad++; $display("FAIL %s_pulses: got %0d expected %0d", name, pulse_cnt - p0, acc ? 1 : 0); end
        n_cmp++; if (parking_slots !== model) begin n_bad++; $display("FAIL %s_slots: got %b expected %b", name, parking_slots, model); end
        n_cmp++; if (capacity !== 3'(4 - $countones(model))) begin n_bad++; $display("FAIL %s_capacity: got %0d expected %0d", name, capacity, 4 - $countones(model)); end
        n_cmp++; if (full !== (model == 4'hF)) begin n_bad++; $display("FAIL %s_full: got %b expected %b", name, full, model == 4'hF); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL %s_queue: %0d events never pulsed, expected 0", name, exp_q.size()); end
    endtask

    task automatic test_entry_timing();
        bit exp_l;
        @(negedge clk);
        switch = 2'd2;
        exp_q.push_back(4'b0100);
        entry_sensor = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (door_open_pulse !== (k == 3)) begin n_bad++; $display("FAIL entry_pulse_k%0d: got %b expected %b", k, door_open_pulse, k == 3); end
        end
        for (int i = 0; i < 20; i++) begin
            exp_l = (i < 4) || (i >= 8 && i < 12);
            n_cmp++;
            if (door_open_light !== exp_l) begin n_bad++; $display("FAIL door_light_i%0d: got %b expected %b", i, door_open_light, exp_l); end
            if (i == 6) entry_sensor = 1'b0;
            @(negedge clk);
        end
        model = 4'b0100;
        n_cmp++; if (parking_slots !== 4'b0100) begin n_bad++; $display("FAIL entry2_slots: got %b expected 0100", parking_slots); end
        n_cmp++; if (capacity !== 3'd3) begin n_bad++; $display("FAIL entry2_capacity: got %0d expected 3", capacity); end
    endtask

    task automatic test_fill_and_reject();
        bit exp_f;
        int p0;
        run_event(1'b1, 1'b0, 2'd0, "fill0");
        run_event(1'b1, 1'b0, 2'd1, "fill1");
        run_event(1'b1, 1'b0, 2'd2, "fill2_occupied");
        run_event(1'b1, 1'b0, 2'd3, "fill3");
        repeat (12) @(negedge clk);
        switch = 2'd0;
        p0 = pulse_cnt;
        entry_sensor = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 10) entry_sensor = 1'b0;
`ifdef PARK_FULL_LIGHT_EN
            exp_f = (k >= 4 && k < 8) || (k >= 12 && k < 16);
`else
            exp_f = 1'b0;
`endif
            n_cmp++;
            if (full_light !== exp_f) begin n_bad++; $display("FAIL full_light_k%0d: got %b expected %b", k, full_light, exp_f); end
            n_cmp++;
            if (door_open_light !== 1'b0) begin n_bad++; $display("FAIL reject_door_light_k%0d: got %b expected 0", k, door_open_light); end
        end
        n_cmp++; if (pulse_cnt != p0) begin n_bad++; $display("FAIL reject_pulses: got %0d expected 0", pulse_cnt - p0); end
        n_cmp++; if (parking_slots !== 4'hF) begin n_bad++; $display("FAIL full_slots: got %b expected 1111", parking_slots); end
        n_cmp++; if (capacity !== 3'd0) begin n_bad++; $display("FAIL full_capacity: got %0d expected 0", capacity); end
        n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL full_flag: got %b expected 1", full); end
    endtask

    task automatic test_exit_and_conflicts();
        run_event(1'b0, 1'b1, 2'd1, "exit1");
        run_event(1'b0, 1'b1, 2'd1, "exit1_repeat");
        run_event(1'b1, 1'b1, 2'd1, "simultaneous");
        run_event(1'b1, 1'b0, 2'd0, "occupied_entry");
    endtask

    task automatic test_reset_mid_blink();
        run_event(1'b0, 1'b1, 2'd0, "exit0");
        n_cmp++; if (door_open_light !== 1'b1) begin n_bad++; $display("FAIL preRst_light: got %b expected 1", door_open_light); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (door_open_light !== 1'b0) begin n_bad++; $display("FAIL async_rst_light: got %b expected 0", door_open_light); end
        n_cmp++; if (parking_slots !== 4'b0000) begin n_bad++; $display("FAIL async_rst_slots: got %b expected 0000", parking_slots); end
        n_cmp++; if (capacity !== 3'd4) begin n_bad++; $display("FAIL async_rst_capacity: got %0d expected 4", capacity); end
        model = 4'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++; if (door_open_light !== 1'b0) begin n_bad++; $display("FAIL post_rst_light: got %b expected 0", door_open_light); end
        run_event(1'b1, 1'b0, 2'd3, "after_reset_entry");
    endtask

    initial begin
        rst_n        = 1'b0;
        entry_sensor = 1'b0;
        exit_sensor  = 1'b0;
        switch       = 2'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_entry_timing();
        test_fill_and_reject();
        test_exit_and_conflicts();
        test_reset_mid_blink();
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
